// File: rtl/keypad_if.sv
// keypad_if: keypad matrix pins and debounced key outputs.
// The scanner uses the master modport; the keypad side uses the slave modport.
interface keypad_if;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    modport master (input col_in, output row_out, key_code, key_valid, key_held);
    modport slave (output col_in, input row_out, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low keypad scanner with press and release debounce.
// Emits one key_valid pulse per accepted press; a held key never auto-repeats.
module keypad_scan #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int ROW_HOLD        = 4
) (
    input logic      clk,
    input logic      rst,
    keypad_if.master kp
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(ROW_HOLD + 1);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE_DB} state_t;
    state_t        state_q, state_d;
    logic [3:0]    c1_q, cs_q;
    logic [3:0]    row_out_q, row_out_d, key_code_q, key_code_d;
    logic [1:0]    row_idx_q, row_idx_d, cand_row_q, cand_row_d, cand_col_q, cand_col_d, low_col;
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          key_valid_q, key_valid_d, key_held_q, key_held_d;

    assign low_col = !cs_q[0] ? 2'd0 : !cs_q[1] ? 2'd1 : !cs_q[2] ? 2'd2 : 2'd3;
    assign cnt_inc = (cnt_q == CW'(DEBOUNCE_CYCLES)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        case (state_q)
            SCAN: begin
                if (hold_q != HW'(ROW_HOLD)) begin
                    hold_d = hold_q + HW'(1);
                end else if (cs_q != 4'hF) begin
                    state_d    = DEBOUNCE;
                    cand_row_d = row_idx_q;
                    cand_col_d = low_col;
                    cnt_d      = CW'(1);
                end else begin
                    row_idx_d = row_idx_q + 2'd1;
                    hold_d    = HW'(1);
                end
            end
            DEBOUNCE: begin
                if (cs_q[cand_col_q]) begin
                    state_d   = SCAN;
                    row_idx_d = row_idx_q + 2'd1;
                    hold_d    = HW'(1);
                end else if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
                    state_d     = PRESSED;
                    key_code_d  = {cand_row_q, cand_col_q};
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (cs_q == 4'hF) begin
                    state_d = RELEASE_DB;
                    cnt_d   = CW'(1);
                end
            end
            RELEASE_DB: begin
                // any low column while releasing is contact bounce, not a new press
                if (cs_q != 4'hF) begin
                    state_d = PRESSED;
                end else if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
                    state_d    = SCAN;
                    key_held_d = 1'b0;
                    row_idx_d  = row_idx_q + 2'd1;
                    hold_d     = HW'(1);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = SCAN;
        endcase
        row_out_d = (state_d == SCAN) ? ~(4'b0001 << row_idx_d) : row_out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            c1_q        <= 4'hF;
            cs_q        <= 4'hF;
            row_out_q   <= 4'hF;
            row_idx_q   <= 2'd0;
            hold_q      <= '0;
            cnt_q       <= '0;
            cand_row_q  <= 2'd0;
            cand_col_q  <= 2'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            c1_q        <= kp.col_in;
            cs_q        <= c1_q;
            row_out_q   <= row_out_d;
            row_idx_q   <= row_idx_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.row_out   = row_out_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed scenarios against a behavioural 4x4 key matrix.
module tb_keypad_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0;
    logic        prev_valid = 1'b0;
    int          checks = 0, failures = 0, pulses = 0, doubles = 0;

    keypad_if kp();
    keypad_scan dut (.clk(clk), .rst(rst), .kp(kp));

    always #5 clk = ~clk;

    always_comb begin
        kp.col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kp.row_out[r]) kp.col_in[c] = 1'b0;
    end

    always @(posedge clk) begin
        if (kp.key_valid) pulses <= pulses + 1;
        if (kp.key_valid && prev_valid) doubles <= doubles + 1;
        prev_valid <= kp.key_valid;
    end

    task automatic wait_pulse(input int limit, output int lat);
        lat = 0;
        while (lat <= limit) begin
            @(negedge clk);
            lat++;
            if (kp.key_valid) return;
        end
    endtask

    task automatic wait_row0;
        logic [3:0] prev;
        int n;
        n = 0;
        prev = kp.row_out;
        while (n < 40 && !(kp.row_out == 4'b1110 && prev != 4'b1110)) begin
            prev = kp.row_out;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 40) begin failures++; $display("FAIL row0_wait got=timeout exp=row0"); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        keys = '0;
        repeat (3) @(negedge clk);
        checks++; if (kp.row_out !== 4'hF) begin failures++; $display("FAIL rst_row_out got=%h exp=f", kp.row_out); end
        checks++; if (kp.key_code !== 4'd0) begin failures++; $display("FAIL rst_key_code got=%h exp=0", kp.key_code); end
        checks++; if (kp.key_valid !== 1'b0) begin failures++; $display("FAIL rst_key_valid got=%b exp=0", kp.key_valid); end
        checks++; if (kp.key_held !== 1'b0) begin failures++; $display("FAIL rst_key_held got=%b exp=0", kp.key_held); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (kp.row_out !== 4'b1110) begin failures++; $display("FAIL first_row got=%b exp=1110", kp.row_out); end
        repeat (3) @(negedge clk);
        checks++; if (kp.row_out !== 4'b1110) begin failures++; $display("FAIL row0_hold got=%b exp=1110", kp.row_out); end
        @(negedge clk);
        checks++; if (kp.row_out !== 4'b1101) begin failures++; $display("FAIL row1_next got=%b exp=1101", kp.row_out); end
    endtask

    task automatic test_clean_press;
        int lat, p0;
        p0 = pulses;
        keys[9] = 1'b1;
        wait_pulse(60, lat);
        checks++; if (lat > 38) begin failures++; $display("FAIL press_latency got=%0d exp<=38", lat); end
        checks++; if (kp.key_code !== 4'd9) begin failures++; $display("FAIL press_code got=%0d exp=9", kp.key_code); end
        checks++; if (kp.key_held !== 1'b1) begin failures++; $display("FAIL press_held got=%b exp=1", kp.key_held); end
        repeat (20) @(negedge clk);
        checks++; if (pulses - p0 != 1) begin failures++; $display("FAIL press_one_pulse got=%0d exp=1", pulses - p0); end
        keys[9] = 1'b0;
        repeat (21) @(negedge clk);
        checks++; if (kp.key_held !== 1'b1) begin failures++; $display("FAIL release_early got=%b exp=1", kp.key_held); end
        @(negedge clk);
        checks++; if (kp.key_held !== 1'b0) begin failures++; $display("FAIL release_fall got=%b exp=0", kp.key_held); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_bounce;
        int lat, p0;
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            keys[7] = ~keys[7];
            repeat (5) @(negedge clk);
        end
        checks++; if (pulses - p0 != 0) begin failures++; $display("FAIL bounce_no_pulse got=%0d exp=0", pulses - p0); end
        keys[7] = 1'b1;
        wait_pulse(60, lat);
        checks++; if (lat < 20 || lat > 38) begin failures++; $display("FAIL bounce_latency got=%0d exp=20..38", lat); end
        checks++; if (kp.key_code !== 4'd7) begin failures++; $display("FAIL bounce_code got=%0d exp=7", kp.key_code); end
        repeat (10) @(negedge clk);
        checks++; if (pulses - p0 != 1) begin failures++; $display("FAIL bounce_one_pulse got=%0d exp=1", pulses - p0); end
        keys = '0;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_glitch;
        int p0, n;
        wait_row0();
        p0 = pulses;
        keys[0] = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (kp.row_out !== 4'b1110) begin failures++; $display("FAIL glitch_frozen got=%b exp=1110", kp.row_out); end
        repeat (2) @(negedge clk);
        keys[0] = 1'b0;
        n = 0;
        while (n < 12 && kp.row_out == 4'b1110) begin @(negedge clk); n++; end
        checks++; if (kp.row_out !== 4'b1101) begin failures++; $display("FAIL glitch_resume got=%b exp=1101", kp.row_out); end
        repeat (30) @(negedge clk);
        checks++; if (pulses - p0 != 0) begin failures++; $display("FAIL glitch_pulse got=%0d exp=0", pulses - p0); end
    endtask

    task automatic test_multi_key;
        int lat, p0;
        wait_row0();
        p0 = pulses;
        keys[0] = 1'b1;
        keys[15] = 1'b1;
        wait_pulse(60, lat);
        checks++; if (lat > 38) begin failures++; $display("FAIL multi_latency got=%0d exp<=38", lat); end
        checks++; if (kp.key_code !== 4'd0) begin failures++; $display("FAIL multi_code got=%0d exp=0", kp.key_code); end
        keys[5] = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (pulses - p0 != 1) begin failures++; $display("FAIL multi_ignore got=%0d exp=1", pulses - p0); end
        checks++; if (kp.key_held !== 1'b1) begin failures++; $display("FAIL multi_held got=%b exp=1", kp.key_held); end
        keys = '0;
        repeat (30) @(negedge clk);
        checks++; if (kp.key_held !== 1'b0) begin failures++; $display("FAIL multi_release got=%b exp=0", kp.key_held); end
        keys[5] = 1'b1;
        keys[6] = 1'b1;
        wait_pulse(60, lat);
        checks++; if (lat > 38) begin failures++; $display("FAIL lowcol_latency got=%0d exp<=38", lat); end
        checks++; if (kp.key_code !== 4'd5) begin failures++; $display("FAIL lowcol_code got=%0d exp=5", kp.key_code); end
        keys = '0;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset_mid_press;
        int lat;
        keys[9] = 1'b1;
        wait_pulse(60, lat);
        repeat (3) @(negedge clk);
        checks++; if (kp.key_held !== 1'b1) begin failures++; $display("FAIL mid_held got=%b exp=1", kp.key_held); end
        #1 rst = 1'b1;
        #1;
        checks++; if (kp.row_out !== 4'hF) begin failures++; $display("FAIL mid_row_out got=%h exp=f", kp.row_out); end
        checks++; if (kp.key_code !== 4'd0) begin failures++; $display("FAIL mid_code got=%0d exp=0", kp.key_code); end
        checks++; if (kp.key_held !== 1'b0) begin failures++; $display("FAIL mid_key_held got=%b exp=0", kp.key_held); end
        checks++; if (kp.key_valid !== 1'b0) begin failures++; $display("FAIL mid_key_valid got=%b exp=0", kp.key_valid); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_pulse(60, lat);
        checks++; if (lat > 38) begin failures++; $display("FAIL mid_repress_latency got=%0d exp<=38", lat); end
        checks++; if (kp.key_code !== 4'd9) begin failures++; $display("FAIL mid_repress_code got=%0d exp=9", kp.key_code); end
        keys = '0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_multi_key();
        test_reset_mid_press();
        checks++; if (doubles != 0) begin failures++; $display("FAIL valid_spacing got=%0d exp=0", doubles); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
